// File: rtl/serial_mag_compare_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, result bundle and reset values.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic b_gt_a;
    logic a_gt_b;
  } cmp_result_t;

  localparam state_t      STATE_RESET  = IDLE;
  localparam cmp_result_t RESULT_RESET = '0;

endpackage

// File: rtl/serial_mag_compare_if.sv
// Start/done handshake, operand and result bundle for serial_mag_compare.
interface serial_mag_compare_if #(
  parameter int W = 4
) ();
  import cmp_pkg::*;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic         b_gt_a;
  logic         a_gt_b;

  modport master (
    output start, a, b,
    input  busy, done, eq, b_gt_a, a_gt_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, eq, b_gt_a, a_gt_b
  );

endinterface

// File: rtl/serial_mag_compare_slice.sv
// One-bit compare slice: folds a bit pair into the running equal/greater (b over a) cascade terms.
module bit_compare_slice (
  input  logic a1,
  input  logic b1,
  input  logic e0,
  input  logic g0,
  output logic e1,
  output logic g1
);

  assign e1 = ~(a1 ^ b1) & e0;
  assign g1 = (~a1 & b1 & e0) | g0;

endmodule

// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned comparator, MSB first, one bit pair per clock through a single slice.
// Optional macro EARLY_EXIT_EN ends the run at the first differing bit; results are unaffected.
module serial_mag_compare
  import cmp_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_mag_compare_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  state_t      state;
  state_t      state_next;
  logic [W-1:0] sa;
  logic [W-1:0] sb;
  logic        e_r;
  logic        g_r;
  logic        e_next;
  logic        g_next;
  logic [CW-1:0] cnt;
  logic        last_bit;
  cmp_result_t result_r;

  bit_compare_slice u_slice (
    .a1 (sa[W-1]),
    .b1 (sb[W-1]),
    .e0 (e_r),
    .g0 (g_r),
    .e1 (e_next),
    .g1 (g_next)
  );

  always_comb begin
    last_bit = (cnt == '0);
`ifdef EARLY_EXIT_EN
    // Once the words differ the remaining bits cannot change the outcome.
    last_bit = last_bit | ~e_next;
`endif
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STATE_RESET;
      sa       <= '0;
      sb       <= '0;
      e_r      <= 1'b0;
      g_r      <= 1'b0;
      cnt      <= '0;
      result_r <= RESULT_RESET;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            e_r <= 1'b1;
            g_r <= 1'b0;
            cnt <= CW'(W - 1);
          end
        end
        RUN: begin
          e_r <= e_next;
          g_r <= g_next;
          sa  <= sa << 1;
          sb  <= sb << 1;
          cnt <= cnt - 1'b1;
          // Results are captured on the way into DONE and then held until the next finish.
          if (last_bit) begin
            result_r <= '{eq: e_next, b_gt_a: g_next, a_gt_b: ~e_next & ~g_next};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.eq     = result_r.eq;
  assign bus.b_gt_a = result_r.b_gt_a;
  assign bus.a_gt_b = result_r.a_gt_b;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Scoreboard bench for serial_mag_compare at W=4, W=1 and W=8 (honours EARLY_EXIT_EN if defined).
module tb_serial_mag_compare;
  import cmp_pkg::*;

  typedef struct {
    cmp_result_t res;
    int          lat;
  } exp_t;

`ifdef EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_mag_compare_if #(.W(4)) if4 ();
  serial_mag_compare_if #(.W(1)) if1 ();
  serial_mag_compare_if #(.W(8)) if8 ();

  serial_mag_compare #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_mag_compare #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_mag_compare #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  int          checks = 0;
  int          errors = 0;
  exp_t        q4[$];
  exp_t        q1[$];
  exp_t        q8[$];
  cmp_result_t prev4 = '0;

  function automatic cmp_result_t model(input logic [7:0] av, input logic [7:0] bv);
    cmp_result_t r;
    r.eq     = (av == bv);
    r.b_gt_a = (bv > av);
    r.a_gt_b = (av > bv);
    return r;
  endfunction

  function automatic int exp_lat(input logic [7:0] av, input logic [7:0] bv, input int w);
    int first;
    first = w;
    for (int i = 0; i < w; i++) begin
      if (first == w && av[w-1-i] != bv[w-1-i]) first = i;
    end
    return (EARLY && first < w) ? first + 2 : w + 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if4.busy, if4.done, if4.eq, if4.b_gt_a, if4.a_gt_b} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_w4: got %b expected 00000",
               {if4.busy, if4.done, if4.eq, if4.b_gt_a, if4.a_gt_b});
    end
    checks++;
    if ({if1.busy, if1.done, if1.eq, if1.b_gt_a, if1.a_gt_b,
         if8.busy, if8.done, if8.eq, if8.b_gt_a, if8.a_gt_b} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_w1_w8: got %b expected 0",
               {if1.busy, if1.done, if1.eq, if1.b_gt_a, if1.a_gt_b,
                if8.busy, if8.done, if8.eq, if8.b_gt_a, if8.a_gt_b});
    end
    rst = 1'b0;
    prev4 = '0;
  endtask

  // W=4 transaction; inject pulses start at c2 and in the DONE cycle with other operands.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input bit inject);
    exp_t e;
    int   lat;
    bit   seen;
    e.res = model({4'b0, av}, {4'b0, bv});
    e.lat = exp_lat({4'b0, av}, {4'b0, bv}, 4);
    q4.push_back(e);
    @(negedge clk);
    if4.a = av;
    if4.b = bv;
    if4.start = 1'b1;
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if4.start = inject && (k == 2);
      if (inject && k == 2) begin
        if4.a = ~av;
        if4.b = ~bv;
      end
      if (if4.done) begin
        seen = 1'b1;
        lat = k;
      end else if (k == 1) begin
        checks++;
        if (if4.busy !== 1'b1 || {if4.eq, if4.b_gt_a, if4.a_gt_b} !== prev4) begin
          errors++;
          $display("[TB] FAIL run_hold_prev: busy=%b res=%b expected busy=1 res=%b",
                   if4.busy, {if4.eq, if4.b_gt_a, if4.a_gt_b}, prev4);
        end
      end
    end
    if (inject && seen) begin
      if4.start = 1'b1;
      if4.a = ~av;
      if4.b = bv ^ 4'b0101;
    end
    e = q4.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin
      errors++;
      $display("[TB] FAIL latency_w4 a=%h b=%h: got %0d expected %0d (0 = timeout)", av, bv, lat, e.lat);
    end
    checks++;
    if ({if4.eq, if4.b_gt_a, if4.a_gt_b} !== e.res) begin
      errors++;
      $display("[TB] FAIL result_w4 a=%h b=%h: got %b expected %b",
               av, bv, {if4.eq, if4.b_gt_a, if4.a_gt_b}, e.res);
    end
    @(negedge clk);
    if4.start = 1'b0;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || {if4.eq, if4.b_gt_a, if4.a_gt_b} !== e.res) begin
      errors++;
      $display("[TB] FAIL after_done_w4: busy=%b done=%b res=%b expected busy=0 done=0 res=%b",
               if4.busy, if4.done, {if4.eq, if4.b_gt_a, if4.a_gt_b}, e.res);
    end
    prev4 = e.res;
  endtask

  task automatic run1(input logic av, input logic bv);
    exp_t e;
    int   lat;
    e.res = model({7'b0, av}, {7'b0, bv});
    e.lat = exp_lat({7'b0, av}, {7'b0, bv}, 1);
    q1.push_back(e);
    @(negedge clk);
    if1.a = av;
    if1.b = bv;
    if1.start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if1.start = 1'b0;
      if (if1.done) lat = k;
    end
    e = q1.pop_front();
    checks++;
    if (lat != e.lat || {if1.eq, if1.b_gt_a, if1.a_gt_b} !== e.res) begin
      errors++;
      $display("[TB] FAIL w1 a=%b b=%b: got lat=%0d res=%b expected lat=%0d res=%b",
               av, bv, lat, {if1.eq, if1.b_gt_a, if1.a_gt_b}, e.lat, e.res);
    end
    @(negedge clk);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    int   lat;
    e.res = model(av, bv);
    e.lat = exp_lat(av, bv, 8);
    q8.push_back(e);
    @(negedge clk);
    if8.a = av;
    if8.b = bv;
    if8.start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 16 && lat == 0; k++) begin
      @(negedge clk);
      if8.start = 1'b0;
      if (if8.done) lat = k;
    end
    e = q8.pop_front();
    checks++;
    if (lat != e.lat || {if8.eq, if8.b_gt_a, if8.a_gt_b} !== e.res) begin
      errors++;
      $display("[TB] FAIL w8 a=%h b=%h: got lat=%0d res=%b expected lat=%0d res=%b",
               av, bv, lat, {if8.eq, if8.b_gt_a, if8.a_gt_b}, e.lat, e.res);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    run4(4'b1010, 4'b1011, 1'b0);
    run4(4'hF, 4'hF, 1'b0);
    run4(4'b1000, 4'b0111, 1'b0);
    run4(4'b0000, 4'b0000, 1'b0);
    run4(4'b0001, 4'b0000, 1'b0);
    run4(4'b0110, 4'b1001, 1'b0);
  endtask

  task automatic test_ignored_start();
    run4(4'b1010, 4'b1011, 1'b1);
    run4(4'b0011, 4'b0011, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end
  endtask

  task automatic test_mid_run_reset();
    int done_seen;
    @(negedge clk);
    if4.a = 4'b1010;
    if4.b = 4'b1011;
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({if4.busy, if4.done, if4.eq, if4.b_gt_a, if4.a_gt_b} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL mid_run_reset: got %b expected 00000",
               {if4.busy, if4.done, if4.eq, if4.b_gt_a, if4.a_gt_b});
    end
    prev4 = '0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if4.done || if4.busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("[TB] FAIL no_done_after_reset: got %0d active cycles expected 0", done_seen);
    end
    run4(4'b1100, 4'b0100, 1'b0);
  endtask

  task automatic test_w1();
    run1(1'b0, 1'b1);
    run1(1'b1, 1'b0);
    run1(1'b1, 1'b1);
    run1(1'b0, 1'b0);
  endtask

  task automatic test_w8_sweep();
    run8(8'h00, 8'h00);
    run8(8'hFF, 8'hFF);
    run8(8'h80, 8'h7F);
    run8(8'h00, 8'h01);
    for (int i = 0; i < 1000; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    test_reset();
    test_basic();
    test_ignored_start();
    test_back_to_back();
    test_mid_run_reset();
    test_w1();
    test_w8_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
